spi_count_slave: RTL and testbench

SPI_COUNT_SLAVE -- requirements
Module: spi_count_slave

---
 rtl/spi_count_pkg.sv | 20 ++
 rtl/spi_count_slave_sync_edge_detect.sv | 55 +++++
 rtl/spi_count_slave.sv | 143 ++++++++++++++
 tb/tb_spi_count_slave.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/spi_count_pkg.sv
// Shared constants and FSM state type for the SPI count slave.
// The top and its synchronizer sub-module import this package.
package spi_count_pkg;

   localparam int FRAME_BITS    = 16;
   localparam int DEF_WIDTH     = 14;
   localparam int DEF_MAX_COUNT = 9999;

   // Bit counter holds 0..17; 17 marks an overrun (more than FRAME_BITS clocks)
   localparam int                  CNT_BITS = 5;
   localparam logic [CNT_BITS-1:0] BIT_SAT  = CNT_BITS'(FRAME_BITS + 1);
   localparam logic [CNT_BITS-1:0] BIT_FULL = CNT_BITS'(FRAME_BITS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

endpackage

// File: rtl/spi_count_slave_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input with rise/fall pulses.
// Edges are suppressed until the chain holds real samples after reset.
module sync_edge_detect #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   localparam int SETTLE = STAGES + 1;
   localparam int CW     = $clog2(SETTLE + 1);

   logic [STAGES-1:0] sync_reg;
   logic              prev_reg;
   logic [CW-1:0]     settle_reg;
   logic              settled;
   logic              sync_out;

   generate
      if (STAGES > 1) begin : g_chain
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) sync_reg <= {STAGES{RST_VAL}};
            else      sync_reg <= {sync_reg[STAGES-2:0], din};
         end
      end else begin : g_single
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) sync_reg <= RST_VAL;
            else      sync_reg <= din;
         end
      end
   endgenerate

   assign sync_out = sync_reg[STAGES-1];

   // The reset value differs from the live input, so the first transition
   // after reset release is an artefact and must not count as an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_reg   <= RST_VAL;
         settle_reg <= '0;
      end else begin
         prev_reg <= sync_out;
         if (!settled) settle_reg <= settle_reg + 1'b1;
      end
   end

   assign settled = (settle_reg == CW'(SETTLE));
   assign rise    = settled &  sync_out & ~prev_reg;
   assign fall    = settled & ~sync_out &  prev_reg;

endmodule

// File: rtl/spi_count_slave.sv
// SPI mode-0 slave that receives a 16-bit frame, range-checks the low WIDTH
// bits and publishes them as count_out; miso reads back the previous count.
module spi_count_slave
   import spi_count_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int MAX_COUNT   = DEF_MAX_COUNT,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             mosi,
   output logic             miso,
   output logic [WIDTH-1:0] count_out,
   output logic             count_valid,
   output logic             frame_err
);

   localparam logic [WIDTH-1:0] MAX_VAL = MAX_COUNT[WIDTH-1:0];

   logic sclk_rise, sclk_fall;
   logic cs_rise, cs_fall;
   logic mosi_s;

   logic [SYNC_STAGES-1:0] mosi_sync_reg;

   state_t                state_reg;
   logic [CNT_BITS-1:0]   bit_cnt_reg;
   logic [WIDTH-1:0]      rx_reg;
   logic [FRAME_BITS-1:0] tx_reg;
   logic [FRAME_BITS-1:0] tx_load;
   logic [WIDTH-1:0]      count_reg;
   logic                  valid_reg;
   logic                  err_reg;
   logic                  miso_reg;
   logic                  pending_reg;

   sync_edge_detect #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_sclk_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   sync_edge_detect #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_cs_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (cs_n),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   // mosi only needs the same latency as sclk so it is sampled aligned
   generate
      if (SYNC_STAGES > 1) begin : g_mosi_chain
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) mosi_sync_reg <= '0;
            else      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
         end
      end else begin : g_mosi_single
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) mosi_sync_reg <= '0;
            else      mosi_sync_reg <= mosi;
         end
      end
   endgenerate

   assign mosi_s  = mosi_sync_reg[SYNC_STAGES-1];
   assign tx_load = FRAME_BITS'(count_reg);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= ST_IDLE;
         bit_cnt_reg <= '0;
         rx_reg      <= '0;
         tx_reg      <= '0;
         count_reg   <= '0;
         valid_reg   <= 1'b0;
         err_reg     <= 1'b0;
         miso_reg    <= 1'b0;
         pending_reg <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         unique case (state_reg)
            ST_IDLE: begin
               miso_reg <= 1'b0;
               if (cs_fall || pending_reg) begin
                  pending_reg <= 1'b0;
                  bit_cnt_reg <= '0;
                  rx_reg      <= '0;
                  tx_reg      <= tx_load;
                  miso_reg    <= tx_load[FRAME_BITS-1];
                  state_reg   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (cs_rise) begin
                  // Verdict is registered here so the pulse is visible in CHECK
                  miso_reg  <= 1'b0;
                  state_reg <= ST_CHECK;
                  if (bit_cnt_reg == BIT_FULL && rx_reg <= MAX_VAL) begin
                     count_reg <= rx_reg;
                     valid_reg <= 1'b1;
                  end else begin
                     err_reg <= 1'b1;
                  end
               end else begin
                  if (sclk_rise) begin
                     rx_reg <= {rx_reg[WIDTH-2:0], mosi_s};
                     if (bit_cnt_reg != BIT_SAT) bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  end
                  if (sclk_fall) begin
                     tx_reg   <= {tx_reg[FRAME_BITS-2:0], 1'b0};
                     miso_reg <= tx_reg[FRAME_BITS-2];
                  end
               end
            end
            ST_CHECK: begin
               // A select arriving now must still start the next frame
               if (cs_fall) pending_reg <= 1'b1;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign miso        = miso_reg;
   assign count_out   = count_reg;
   assign count_valid = valid_reg;
   assign frame_err   = err_reg;

endmodule

// File: tb/tb_spi_count_slave.sv
// Directed bench for spi_count_slave: frames are bit-banged, expected
// verdicts queued at send time and checked when the pulses appear.
module tb_spi_count_slave;

   localparam int W = 14;

   logic         clk = 1'b0;
   logic         rst;
   logic         sclk;
   logic         cs_n;
   logic         mosi;
   logic         miso;
   logic [W-1:0] count_out;
   logic         count_valid;
   logic         frame_err;

   typedef struct {
      logic         is_valid;
      logic [W-1:0] value;
      string        tag;
   } exp_t;

   exp_t         sb[$];
   int           compared   = 0;
   int           mismatched = 0;
   logic [W-1:0] model_count = '0;
   logic [31:0]  miso_cap;

   spi_count_slave #(
      .WIDTH       (W),
      .MAX_COUNT   (9999),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sclk        (sclk),
      .cs_n        (cs_n),
      .mosi        (mosi),
      .miso        (miso),
      .count_out   (count_out),
      .count_valid (count_valid),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Clock nbits of data out MSB first, capturing miso just before each rise
   task automatic clock_bits(input logic [31:0] data, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         mosi = data[nbits-1-i];
         wait_clk(8);
         miso_cap = {miso_cap[30:0], miso};
         sclk = 1'b1;
         wait_clk(8);
         sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [31:0] data, input int nbits, input string tag, input int gap);
      logic         accept;
      logic [15:0]  exp_miso;
      exp_t         e;
      accept   = (nbits == 16) && (data[W-1:0] <= 14'd9999);
      exp_miso = {2'b00, model_count};
      e.is_valid = accept;
      e.value    = accept ? data[W-1:0] : model_count;
      e.tag      = tag;
      sb.push_back(e);
      miso_cap = '0;
      cs_n = 1'b0;
      wait_clk(4);
      clock_bits(data, nbits);
      wait_clk(4);
      cs_n = 1'b1;
      if (nbits == 16) check({tag, "_miso"}, {16'h0, miso_cap[15:0]}, {16'h0, exp_miso});
      if (accept) model_count = data[W-1:0];
      wait_clk(gap);
   endtask

   // Scoreboard consumer: every result pulse must match the oldest expectation
   always @(negedge clk) begin
      if (rst === 1'b1 && (count_valid || frame_err)) begin
         check("pulse_exclusive", {31'h0, count_valid & frame_err}, 32'h0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", {30'h0, count_valid, frame_err}, 32'h0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_kind"}, {30'h0, count_valid, frame_err}, {30'h0, e.is_valid, ~e.is_valid});
            check({e.tag, "_value"}, {18'h0, count_out}, {18'h0, e.value});
         end
      end
   end

   initial begin
      rst  = 1'b0;
      sclk = 1'b0;
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_clk(3);
      check("rst_count_out", {18'h0, count_out}, 32'h0);
      check("rst_count_valid", {31'h0, count_valid}, 32'h0);
      check("rst_frame_err", {31'h0, frame_err}, 32'h0);
      check("rst_miso", {31'h0, miso}, 32'h0);
      rst = 1'b1;
      wait_clk(10);

      send_frame(32'h1234, 16, "f_4660", 10);
      check("hold_4660", {18'h0, count_out}, {18'h0, model_count});
      send_frame(32'h2710, 16, "f_10000", 10);
      check("hold_after_10000", {18'h0, count_out}, 32'd4660);
      send_frame(32'h0ABC, 12, "f_short12", 10);
      send_frame(32'h1_0042, 17, "f_long17", 10);
      check("hold_after_bad_len", {18'h0, count_out}, 32'd4660);

      // sclk activity with cs_n high must be ignored
      for (int i = 0; i < 5; i++) begin
         sclk = 1'b1; wait_clk(4);
         sclk = 1'b0; wait_clk(4);
      end

      send_frame(32'h3FFF, 16, "f_16383", 10);
      send_frame(32'd9999, 16, "f_max", 10);
      send_frame(32'd0, 16, "f_zero", 10);
      check("hold_zero", {18'h0, count_out}, 32'd0);
      send_frame(32'd4660, 16, "f_4660b", 10);

      // Abort a frame with reset after 8 bits; no pulse may follow for it
      cs_n = 1'b0;
      wait_clk(4);
      clock_bits(32'hA5, 8);
      rst = 1'b0;
      wait_clk(3);
      check("midrst_count_out", {18'h0, count_out}, 32'h0);
      check("midrst_miso", {31'h0, miso}, 32'h0);
      model_count = '0;
      rst = 1'b1;
      wait_clk(6);
      clock_bits(32'h5A, 8);
      wait_clk(4);
      cs_n = 1'b1;
      wait_clk(10);
      send_frame(32'h0005, 16, "f_5", 10);
      check("after_rst_5", {18'h0, count_out}, 32'd5);

      send_frame(32'd100, 16, "f_100", 2);
      send_frame(32'd200, 16, "f_200", 10);
      check("b2b_final", {18'h0, count_out}, 32'd200);

      wait_clk(20);
      check("sb_drained", sb.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
